step_sequencer_scheduler: RTL and testbench

//  Tempo-driven step scheduler for the picoversat sound subsystem (clk = 50 MHz).

---
 rtl/step_sequencer_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_step_sequencer_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer_scheduler.sv
// step_sequencer_scheduler
//
// Tempo-driven step scheduler for the sound subsystem. Holds an N-step
// pattern of 8-bit tone codes and advances one step per tempo period. It
// drives the tone generator (frequency code + enable) and a one-hot LED step
// display. The CPU programs it over the peripheral bus. While recording, it
// can capture live keyboard codes into the step that is playing.
//
// Optional feature macro: SEQ_SWING_EN
//   defined   : odd-indexed steps last period + (period >> 2) clocks
//   undefined : every step lasts exactly period clocks
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   sel_i          peripheral select
//   we_i           write enable, qualified by sel_i
//   addr_i         register address (PATTERN 0..N-1, CTRL C, TEMPO D, LEN E, STATUS F)
//   data_in_i      write data
//   data_out_o     registered read data, valid the cycle after a read
//   kbd_in_i       live key code, 0 = no key
//   tone_freq_o    tone code for the sound generator (0 outside PLAY)
//   tone_en_o      sound generator enable (PLAY and non-rest step)
//   led_out_o      one-hot current step while playing or done, 0 when idle
//   step_strobe_o  one-cycle pulse on every step entry

module step_sequencer_scheduler #(
    parameter int unsigned N_STEPS     = 8,
    parameter int unsigned TEMPO_SHIFT = 18
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sel_i,
    input  logic       we_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] data_in_i,
    output logic [7:0] data_out_o,
    input  logic [7:0] kbd_in_i,
    output logic [7:0] tone_freq_o,
    output logic       tone_en_o,
    output logic [7:0] led_out_o,
    output logic       step_strobe_o
);

    localparam int unsigned SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int unsigned LW = $clog2(N_STEPS + 1);
    localparam int unsigned BW = 9 + TEMPO_SHIFT;
    localparam int unsigned PW = BW + 1;

    localparam logic [3:0] ADDR_CTRL   = 4'hC;
    localparam logic [3:0] ADDR_TEMPO  = 4'hD;
    localparam logic [3:0] ADDR_LEN    = 4'hE;
    localparam logic [3:0] ADDR_STATUS = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [PW-1:0] tick_q, tick_d;
    logic [PW-1:0] dur_q, dur_d;
    logic          strobe_q, strobe_d;

    logic [7:0]    pattern_q [N_STEPS];
    logic [2:0]    ctrl_q;
    logic [7:0]    tempo_q;
    logic [LW-1:0] len_q;
    logic [7:0]    data_out_q;

    logic          wrEn, rdEn, ctrlWr, startReq, stopReq;
    logic          patWr, recWr, enterStep, enterDone;
    logic [BW-1:0] basePeriod;
    logic [LW-1:0] lenClamped;
    logic [7:0]    curTone;
    logic [7:0]    rdData;

    // Bus decode. Control registers take priority over pattern addresses so
    // deep patterns never alias CTRL..STATUS.
    assign wrEn     = sel_i & we_i;
    assign rdEn     = sel_i & ~we_i;
    assign ctrlWr   = wrEn && (addr_i == ADDR_CTRL);
    assign startReq = ctrlWr & data_in_i[0] & ~ctrl_q[0];
    assign stopReq  = ctrlWr & ~data_in_i[0];
    assign patWr    = wrEn && (addr_i < ADDR_CTRL) && (32'(addr_i) < N_STEPS);
    assign recWr    = (state_q == PLAY) && ctrl_q[1] && (kbd_in_i != 8'd0);

    // The period comes from the shadowed TEMPO value. It is copied into dur_q
    // only on step entry, so a mid-step TEMPO write leaves the current step alone.
    assign basePeriod = BW'({1'b0, tempo_q} + 9'd1) << TEMPO_SHIFT;

    always_comb begin
        lenClamped = LW'(data_in_i);
        if (data_in_i == 8'd0) begin
            lenClamped = LW'(1);
        end else if (32'(data_in_i) > N_STEPS) begin
            lenClamped = LW'(N_STEPS);
        end
    end

    // Sequencer state machine: explicit stop/start writes override the
    // playback flow; the last step is judged against the live LEN so a
    // lowered LEN ends (or wraps) the pattern at the next boundary.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tick_d    = tick_q;
        dur_d     = dur_q;
        enterStep = 1'b0;
        enterDone = 1'b0;
        if (stopReq) begin
            state_d = IDLE;
            step_d  = '0;
            tick_d  = '0;
        end else if (startReq) begin
            state_d   = PLAY;
            step_d    = '0;
            tick_d    = '0;
            enterStep = 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    if (tick_q == dur_q - PW'(1)) begin
                        tick_d = '0;
                        if (32'(step_q) + 32'd1 < 32'(len_q)) begin
                            step_d    = step_q + SW'(1);
                            enterStep = 1'b1;
                        end else if (ctrl_q[2]) begin
                            step_d    = '0;
                            enterStep = 1'b1;
                        end else begin
                            state_d   = DONE;
                            enterDone = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + PW'(1);
                    end
                end
                DONE: begin
                    tick_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    tick_d  = '0;
                end
            endcase
        end
        if (enterStep) begin
`ifdef SEQ_SWING_EN
            if (step_d[0]) begin
                dur_d = {1'b0, basePeriod} + PW'(basePeriod >> 2);
            end else begin
                dur_d = {1'b0, basePeriod};
            end
`else
            dur_d = {1'b0, basePeriod};
`endif
        end
        strobe_d = enterStep;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            step_q   <= '0;
            tick_q   <= '0;
            dur_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            dur_q    <= dur_d;
            strobe_q <= strobe_d;
        end
    end

    // Register file. The CPU pattern write comes after the keyboard capture,
    // so the CPU wins when both target the same entry in the same cycle.
    // The FSM's auto-clear of run is applied after any CTRL write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N_STEPS; i++) begin
                pattern_q[i] <= 8'd0;
            end
            ctrl_q     <= 3'd0;
            tempo_q    <= 8'd0;
            len_q      <= LW'(N_STEPS);
            data_out_q <= 8'd0;
        end else begin
            if (recWr) begin
                pattern_q[step_q] <= kbd_in_i;
            end
            if (patWr) begin
                pattern_q[addr_i[SW-1:0]] <= data_in_i;
            end
            if (ctrlWr) begin
                ctrl_q <= data_in_i[2:0];
            end
            if (enterDone) begin
                ctrl_q[0] <= 1'b0;
            end
            if (wrEn && (addr_i == ADDR_TEMPO)) begin
                tempo_q <= data_in_i;
            end
            if (wrEn && (addr_i == ADDR_LEN)) begin
                len_q <= lenClamped;
            end
            if (rdEn) begin
                data_out_q <= rdData;
            end
        end
    end

    always_comb begin
        rdData = 8'd0;
        case (addr_i)
            ADDR_CTRL:   rdData = {5'd0, ctrl_q};
            ADDR_TEMPO:  rdData = tempo_q;
            ADDR_LEN:    rdData = 8'(len_q);
            ADDR_STATUS: rdData = {(state_q == DONE), (state_q == PLAY), 2'b00, 4'(step_q)};
            default: begin
                if (32'(addr_i) < N_STEPS) begin
                    rdData = pattern_q[addr_i[SW-1:0]];
                end
            end
        endcase
    end

    // Tone outputs read straight from the pattern, so a recorded key is heard
    // on the cycle after capture. The LED shows only steps 0..7.
    assign curTone       = pattern_q[step_q];
    assign tone_freq_o   = (state_q == PLAY) ? curTone : 8'd0;
    assign tone_en_o     = (state_q == PLAY) && (curTone != 8'd0);
    assign led_out_o     = ((state_q != IDLE) && (32'(step_q) < 32'd8)) ? (8'd1 << step_q) : 8'd0;
    assign step_strobe_o = strobe_q;
    assign data_out_o    = data_out_q;

endmodule

// File: tb/tb_step_sequencer_scheduler.sv
`timescale 1ns/1ps

module tb_step_sequencer_scheduler;

   localparam int NSTEPS = 8;
   localparam int TSHIFT = 2;
   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_DONE = 2;
`ifdef SEQ_SWING_EN
   localparam bit SWING = 1'b1;
`else
   localparam bit SWING = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       sel;
   logic       we;
   logic [3:0] addr;
   logic [7:0] dataIn;
   logic [7:0] dataOut;
   logic [7:0] kbdIn;
   logic [7:0] toneFreq;
   logic       toneEn;
   logic [7:0] ledOut;
   logic       stepStrobe;

   int checkCount = 0;
   int errorCount = 0;

   // Behavioural reference: registers as plain values, playback as a mode
   // plus a countdown of clocks left in the current step.
   logic [7:0] mPattern [NSTEPS];
   logic       mLoop, mRec, mRun;
   logic [7:0] mTempo;
   int         mLen, mMode, mStep, mLeft;
   logic       mStrobe;
   logic [7:0] mDataOut;

   int expTones [5] = '{20, 0, 40, 10, 20};

   always #5 clock = ~clock;

   step_sequencer_scheduler #(
      .N_STEPS(NSTEPS),
      .TEMPO_SHIFT(TSHIFT)
   ) dut (
      .clk_i(clock),
      .rst_i(reset),
      .sel_i(sel),
      .we_i(we),
      .addr_i(addr),
      .data_in_i(dataIn),
      .data_out_o(dataOut),
      .kbd_in_i(kbdIn),
      .tone_freq_o(toneFreq),
      .tone_en_o(toneEn),
      .led_out_o(ledOut),
      .step_strobe_o(stepStrobe)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Clocks a step lasts for the current tempo (swing stretches odd steps).
   function automatic int stepLength(input int idx);
      int base;
      base = (int'(mTempo) + 1) * (1 << TSHIFT);
      if (SWING && (idx % 2 == 1)) return base + base / 4;
      return base;
   endfunction

   function automatic logic [7:0] modelRead(input logic [3:0] a);
      if (a == 4'hC) return {5'd0, mLoop, mRec, mRun};
      if (a == 4'hD) return mTempo;
      if (a == 4'hE) return 8'(mLen);
      if (a == 4'hF) return {(mMode == M_DONE), (mMode == M_PLAY), 2'b00, 4'(mStep)};
      if (int'(a) < NSTEPS) return mPattern[a[2:0]];
      return 8'h00;
   endfunction

   task automatic resetModel();
      for (int i = 0; i < NSTEPS; i++) mPattern[i] = 8'd0;
      mLoop = 1'b0; mRec = 1'b0; mRun = 1'b0;
      mTempo = 8'd0; mLen = NSTEPS;
      mMode = M_IDLE; mStep = 0; mLeft = 0;
      mStrobe = 1'b0; mDataOut = 8'd0;
   endtask

   // Advance the reference by one clock using the inputs present at the edge.
   task automatic modelUpdate();
      int   oldStep, oldLen, oldMode;
      logic oldRun, oldLoop, oldRec, ctrlWrite, enteredDone;
      oldStep = mStep; oldLen = mLen; oldMode = mMode;
      oldRun = mRun; oldLoop = mLoop; oldRec = mRec;
      ctrlWrite = sel && we && (addr == 4'hC);
      enteredDone = 1'b0;
      mStrobe = 1'b0;
      if (sel && !we) mDataOut = modelRead(addr);
      if (ctrlWrite && !dataIn[0]) begin
         mMode = M_IDLE; mStep = 0;
      end else if (ctrlWrite && !oldRun) begin
         mMode = M_PLAY; mStep = 0; mLeft = stepLength(0); mStrobe = 1'b1;
      end else if (oldMode == M_PLAY) begin
         if (mLeft > 1) begin
            mLeft--;
         end else if (oldStep + 1 < oldLen) begin
            mStep = oldStep + 1; mLeft = stepLength(mStep); mStrobe = 1'b1;
         end else if (oldLoop) begin
            mStep = 0; mLeft = stepLength(0); mStrobe = 1'b1;
         end else begin
            mMode = M_DONE; enteredDone = 1'b1;
         end
      end
      if (oldMode == M_PLAY && oldRec && kbdIn != 8'd0) mPattern[oldStep] = kbdIn;
      if (sel && we) begin
         if (int'(addr) < NSTEPS) mPattern[addr[2:0]] = dataIn;
         else if (addr == 4'hC) begin mLoop = dataIn[2]; mRec = dataIn[1]; mRun = dataIn[0]; end
         else if (addr == 4'hD) mTempo = dataIn;
         else if (addr == 4'hE) mLen = (dataIn == 0) ? 1 : ((int'(dataIn) > NSTEPS) ? NSTEPS : int'(dataIn));
      end
      if (enteredDone) mRun = 1'b0;
   endtask

   task automatic compareAll();
      logic [7:0] t;
      t = (mMode == M_PLAY) ? mPattern[mStep] : 8'd0;
      checkOutput("toneFreq", toneFreq, t);
      checkOutput("toneEn", toneEn, (mMode == M_PLAY) && (t != 8'd0));
      checkOutput("ledOut", ledOut, (mMode != M_IDLE) ? (8'd1 << mStep) : 8'd0);
      checkOutput("stepStrobe", stepStrobe, mStrobe);
      checkOutput("dataOut", dataOut, mDataOut);
   endtask

   task automatic applyStimulus(input logic s, input logic w, input logic [3:0] a,
                                input logic [7:0] d, input logic [7:0] k);
      sel = s; we = w; addr = a; dataIn = d; kbdIn = k;
      @(posedge clock);
      modelUpdate();
      #1;
      compareAll();
   endtask

   task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
      applyStimulus(1'b1, 1'b1, a, d, 8'd0);
   endtask

   task automatic busRead(input logic [3:0] a);
      applyStimulus(1'b1, 1'b0, a, 8'd0, 8'd0);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
   endtask

   // Clock until the next step strobe, bounded; returns the cycle count.
   task automatic waitStrobe(output int n);
      n = 0;
      do begin
         applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
         n++;
      end while (!stepStrobe && n < 64);
      if (!stepStrobe) begin
         checkOutput("strobeTimeout", 32'(stepStrobe), 32'd1);
         n = -1;
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulseReset();
      #2 reset = 1'b1;
      #1;
      resetModel();
      checkOutput("rstToneFreq", toneFreq, 8'd0);
      checkOutput("rstToneEn", toneEn, 1'b0);
      checkOutput("rstLed", ledOut, 8'd0);
      checkOutput("rstStrobe", stepStrobe, 1'b0);
      checkOutput("rstDataOut", dataOut, 8'd0);
      #2 reset = 1'b0;
   endtask

   initial begin
      int n, total;
      int r;
      logic [7:0] d;
      reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 4'd0; dataIn = 8'd0; kbdIn = 8'd0;
      resetModel();
      #3;
      compareAll();
      #4 reset = 1'b0;

      // Reset mid-play.
      busWrite(4'd0, 8'h21); busWrite(4'hD, 8'd1); busWrite(4'hC, 8'h05);
      idleCycles(13);
      pulseReset();
      busRead(4'hF); checkOutput("rstStatus", dataOut, 8'h00);
      busRead(4'hE); checkOutput("rstLen", dataOut, 8'd8);

      // Looping pattern with a rest step.
      busWrite(4'd0, 8'd10); busWrite(4'd1, 8'd20); busWrite(4'd2, 8'd0); busWrite(4'd3, 8'd40);
      busWrite(4'hE, 8'd4); busWrite(4'hD, 8'd1); busWrite(4'hC, 8'h05);
      checkOutput("loopStartStrobe", stepStrobe, 1'b1);
      checkOutput("loopTone0", toneFreq, 8'd10);
      for (int k = 0; k < 5; k++) begin
         waitStrobe(n);
         checkOutput("loopInterval", n, 8);
         checkOutput("loopTone", toneFreq, expTones[k]);
         checkOutput("loopToneEn", toneEn, expTones[k] != 0);
      end

      // One-shot play ends in DONE.
      busWrite(4'hC, 8'h00); busWrite(4'hC, 8'h01);
      idleCycles(40);
      checkOutput("doneToneEn", toneEn, 1'b0);
      busRead(4'hF); checkOutput("doneStatus", dataOut, 8'h83);
      busRead(4'hC); checkOutput("doneCtrl", dataOut, 8'h00);

      // Record, then a CPU write colliding with a key capture.
      busWrite(4'hC, 8'h00); busWrite(4'hC, 8'h07);
      waitStrobe(n); waitStrobe(n);
      checkOutput("recLed", ledOut, 8'h04);
      applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 8'h33);
      checkOutput("recTone", toneFreq, 8'h33);
      busRead(4'd2); checkOutput("recRead", dataOut, 8'h33);
      applyStimulus(1'b1, 1'b1, 4'd2, 8'h11, 8'h55);
      busRead(4'd2); checkOutput("cpuWinsRead", dataOut, 8'h11);
      checkOutput("cpuWinsTone", toneFreq, 8'h11);
      busWrite(4'hC, 8'h00);

      // Shadowed TEMPO and LEN clamping.
      busWrite(4'hD, 8'd1); busWrite(4'hE, 8'd4); busWrite(4'hC, 8'h01);
      idleCycles(3);
      busWrite(4'hD, 8'd3);
      waitStrobe(n); total = 4 + n;
      checkOutput("tempoCurStep", total, 8);
      waitStrobe(n); checkOutput("tempoNextStep", n, SWING ? 20 : 16);
      waitStrobe(n); checkOutput("tempoEvenStep", n, 16);
      busWrite(4'hE, 8'd0); busRead(4'hE); checkOutput("lenZero", dataOut, 8'd1);
      busWrite(4'hE, 8'd20); busRead(4'hE); checkOutput("lenClamp", dataOut, 8'd8);
      busWrite(4'hC, 8'h00);

      // Step lengths at TEMPO=3, with or without swing.
      busWrite(4'hD, 8'd3); busWrite(4'hE, 8'd4); busWrite(4'hC, 8'h05);
      for (int k = 0; k < 4; k++) begin
         waitStrobe(n);
         checkOutput("swingLen", n, (SWING && (k % 2 == 1)) ? 20 : 16);
      end
      busWrite(4'hC, 8'h00);

      // Randomized traffic against the reference.
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) pulseReset();
         r = $urandom_range(0, 99);
         d = ($urandom_range(0, 4) == 0) ? 8'(($urandom_range(1, 255))) : 8'd0;
         if (r < 6)
            applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), d);
         else if (r < 9)
            applyStimulus(1'b1, 1'b1, 4'hC, {5'd0, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0)}, d);
         else if (r < 11)
            applyStimulus(1'b1, 1'b1, 4'hD, 8'($urandom_range(0, 3)), d);
         else if (r < 13)
            applyStimulus(1'b1, 1'b1, 4'hE, 8'($urandom_range(0, 10)), d);
         else if (r < 30)
            applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'd0, d);
         else
            applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, d);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
